// File: rtl/poly_mult_seq.sv
// Sequencer for an NTT-based negacyclic polynomial multiplier: latches operands,
// drives the forward/inverse NTT load and enable strobes, and captures the product.
module poly_mult_seq #(
    parameter int N        = 17,
    parameter int D        = 16,
    parameter int NTT_CYC  = 15,
    parameter int INTT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*D-1:0]   a_in,
    input  logic [N*D-1:0]   b_in,
    output logic [N*D-1:0]   ntt_a_op,
    output logic [N*D-1:0]   ntt_b_op,
    output logic             ntt_load,
    output logic             ntt_en,
    output logic             intt_load,
    output logic             intt_en,
    input  logic [N*D-1:0]   intt_res,
    output logic [N*D-1:0]   c_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             abort,
    output logic             busy,
    output logic [7:0]       jobs_done
);

    localparam int MAX_CYC = (NTT_CYC > INTT_CYC) ? NTT_CYC : INTT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] NTT_LAST  = CW'(NTT_CYC - 1);
    localparam logic [CW-1:0] INTT_LAST = CW'(INTT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_NTT,
        S_RUN_NTT,
        S_LOAD_INTT,
        S_RUN_INTT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   step;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            step      <= '0;
            ntt_a_op  <= '0;
            ntt_b_op  <= '0;
            c_out     <= '0;
            jobs_done <= '0;
        end else if (abort) begin
            // Cancel wins everywhere, including over a pending result handshake.
            state <= S_IDLE;
            step  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ntt_a_op <= a_in;
                        ntt_b_op <= b_in;
                        state    <= S_LOAD_NTT;
                    end
                end
                S_LOAD_NTT: begin
                    step  <= '0;
                    state <= S_RUN_NTT;
                end
                S_RUN_NTT: begin
                    if (step == NTT_LAST) begin
                        step  <= '0;
                        state <= S_LOAD_INTT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_LOAD_INTT: begin
                    step  <= '0;
                    state <= S_RUN_INTT;
                end
                S_RUN_INTT: begin
                    if (step == INTT_LAST) begin
                        step  <= '0;
                        state <= S_CAPTURE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    c_out <= intt_res;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        jobs_done <= jobs_done + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of the state register: one-hot by construction.
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign ntt_load  = (state == S_LOAD_NTT);
    assign ntt_en    = (state == S_RUN_NTT);
    assign intt_load = (state == S_LOAD_INTT);
    assign intt_en   = (state == S_RUN_INTT);
    assign out_valid = (state == S_DONE);

endmodule
